// File: rtl/mig_arbiter.sv
// mig_arbiter: two-requester front end for a MIG user interface.
//   A write requester streams 32-bit words into consecutive addresses; the address
//   restarts at START_ADDRESS after a word marked wr_frame_end. A read requester issues
//   single reads. One command is in flight at a time; ties are round-robin.
// Ports:
//   ui_clk, ui_clk_sync_rst        clock and synchronous active-high reset
//   init_calib_complete            MIG calibration done; grants blocked while low
//   wr_valid/wr_ready/wr_data/wr_frame_end   write requester handshake
//   rd_valid/rd_ready/rd_addr      read requester handshake
//   rd_data/rd_data_valid          read return, passed straight through from the MIG
//   frame_done                     one-cycle pulse when the last word of a frame completes
//   app_*                          MIG native user interface
module mig_arbiter #(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = '0,
   parameter int unsigned ADDR_STEP = 32,
   parameter int unsigned MAX_RD_OUTSTANDING = 4
) (
   input  logic                    ui_clk,
   input  logic                    ui_clk_sync_rst,
   input  logic                    init_calib_complete,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_frame_end,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_data_valid,
   output logic                    frame_done,
   output logic [ADDR_WIDTH-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [DATA_WIDTH-1:0]   app_wdf_data,
   output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   input  logic                    app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid
);

   localparam int unsigned CntW = $clog2(MAX_RD_OUTSTANDING) + 1;

   typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue} state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic                    frame_end_q;
   logic                    last_rd_q;   // 1 = most recent grant went to the reader
   logic [CntW-1:0]         rd_out_q;

   logic can_grant, rd_ok, rd_cmd_acc, wr_cmd_done, wr_data_done;

   assign rd_data       = app_rd_data;
   assign rd_data_valid = app_rd_data_valid;
   assign app_wdf_mask  = '0;

   assign can_grant = (state_q == StIdle) && init_calib_complete && !ui_clk_sync_rst;
   assign rd_ok     = rd_valid && (rd_out_q < CntW'(MAX_RD_OUTSTANDING));
   // A blocked reader never stalls the writer; on a real tie the loser of last time wins.
   assign wr_ready  = can_grant && wr_valid && (!rd_ok || last_rd_q);
   assign rd_ready  = can_grant && rd_ok && (!wr_valid || !last_rd_q);

   assign rd_cmd_acc   = (state_q == StRdIssue) && app_en && app_rdy;
   // Each half of a write is finished once its enable is low or is being accepted now.
   assign wr_cmd_done  = !app_en || app_rdy;
   assign wr_data_done = !app_wdf_wren || app_wdf_rdy;

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         state_q      <= StIdle;
         wr_addr_q    <= START_ADDRESS;
         frame_end_q  <= 1'b0;
         last_rd_q    <= 1'b1;
         rd_out_q     <= '0;
         frame_done   <= 1'b0;
         app_addr     <= '0;
         app_cmd      <= 3'b000;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_end  <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (rd_cmd_acc && !app_rd_data_valid) begin
            rd_out_q <= rd_out_q + 1'b1;
         end else if (app_rd_data_valid && !rd_cmd_acc && (rd_out_q != '0)) begin
            rd_out_q <= rd_out_q - 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (wr_ready) begin
                  app_addr     <= wr_addr_q;
                  app_cmd      <= 3'b000;
                  app_wdf_data <= wr_data;
                  frame_end_q  <= wr_frame_end;
                  app_en       <= 1'b1;
                  app_wdf_wren <= 1'b1;
                  app_wdf_end  <= 1'b1;
                  last_rd_q    <= 1'b0;
                  state_q      <= StWrIssue;
               end else if (rd_ready) begin
                  app_addr  <= rd_addr;
                  app_cmd   <= 3'b001;
                  app_en    <= 1'b1;
                  last_rd_q <= 1'b1;
                  state_q   <= StRdIssue;
               end
            end
            StWrIssue: begin
               if (app_rdy) begin
                  app_en <= 1'b0;
               end
               if (app_wdf_rdy) begin
                  app_wdf_wren <= 1'b0;
                  app_wdf_end  <= 1'b0;
               end
               if (wr_cmd_done && wr_data_done) begin
                  state_q <= StIdle;
                  if (frame_end_q) begin
                     wr_addr_q  <= START_ADDRESS;
                     frame_done <= 1'b1;
                  end else begin
                     wr_addr_q <= wr_addr_q + ADDR_WIDTH'(ADDR_STEP);
                  end
               end
            end
            StRdIssue: begin
               if (app_rdy) begin
                  app_en  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mig_arbiter.sv
// Bench for mig_arbiter: reset/grant vector table, directed multi-cycle sequences, then
// random traffic against a transaction-level model of the expected MIG command stream.
module tb_mig_arbiter;
   localparam int unsigned AW = 28;
   localparam int unsigned DW = 32;

   logic          ui_clk = 1'b0;
   logic          ui_clk_sync_rst;
   logic          init_calib_complete;
   logic          wr_valid, wr_ready, wr_frame_end;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid, frame_done;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en, app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [3:0]    app_wdf_mask;
   logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;

   mig_arbiter dut (
      .ui_clk              (ui_clk),
      .ui_clk_sync_rst     (ui_clk_sync_rst),
      .init_calib_complete (init_calib_complete),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_data             (wr_data),
      .wr_frame_end        (wr_frame_end),
      .rd_valid            (rd_valid),
      .rd_ready            (rd_ready),
      .rd_addr             (rd_addr),
      .rd_data             (rd_data),
      .rd_data_valid       (rd_data_valid),
      .frame_done          (frame_done),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid)
   );

   always #5 ui_clk = ~ui_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge ui_clk);
      #1;
   endtask

   task automatic do_reset;
      ui_clk_sync_rst = 1'b1;
      init_calib_complete = 1'b0;
      wr_valid = 1'b0; wr_data = '0; wr_frame_end = 1'b0;
      rd_valid = 1'b0; rd_addr = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      app_rd_data = '0; app_rd_data_valid = 1'b0;
      tick;
      ui_clk_sync_rst = 1'b0;
   endtask

   task automatic wait_ready(input bit is_rd, input string name);
      int n = 0;
      #1;
      while (((is_rd ? rd_ready : wr_ready) !== 1'b1) && n < 20) begin
         tick;
         n++;
      end
      chk1(name, is_rd ? rd_ready : wr_ready, 1'b1);
   endtask

   // Holds rd_valid with app_rdy high and counts read commands the MIG would accept.
   task automatic count_reads(input int cycles, output int n);
      rd_valid = 1'b1;
      app_rdy  = 1'b1;
      n = 0;
      repeat (cycles) begin
         #1;
         if (app_en && app_rdy && app_cmd == 3'b001) n++;
         tick;
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          fe;
   } wr_t;

   wr_t           wq[$];      // accepted writes not yet fully taken by the MIG
   logic [AW-1:0] rq[$];      // accepted reads whose command is not yet taken
   logic [AW-1:0] m_waddr;
   int            m_out;      // reads taken by the MIG, data not yet returned
   bit            m_last_rd, w_cmd_done, w_data_done, exp_fd, wr_acc, rd_acc;
   int            grants;

   task automatic model_reset;
      wq.delete(); rq.delete();
      m_waddr = '0; m_out = 0; m_last_rd = 1'b1;
      w_cmd_done = 1'b0; w_data_done = 1'b0; exp_fd = 1'b0;
      wr_acc = 1'b0; rd_acc = 1'b0; grants = 0;
   endtask

   task automatic rand_cycle(input bit quiet);
      bit pending, active, rd_ok, exp_w, exp_r, exp_en, exp_wren;
      if (quiet) begin
         wr_valid = 1'b0; rd_valid = 1'b0;
         app_rdy = 1'b1; app_wdf_rdy = 1'b1; init_calib_complete = 1'b1;
      end else begin
         if (!wr_valid || wr_acc) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data = $urandom;
            wr_frame_end = ($urandom_range(0, 3) == 0);
         end
         if (!rd_valid || rd_acc) begin
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom);
         end
         init_calib_complete = ($urandom_range(0, 7) != 0);
         app_rdy = 1'($urandom_range(0, 1));
         app_wdf_rdy = 1'($urandom_range(0, 1));
      end
      app_rd_data_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
      app_rd_data = $urandom;
      #1;
      pending = (wq.size() != 0) || (rq.size() != 0);
      active  = init_calib_complete && !pending;
      rd_ok   = rd_valid && (m_out < 4);
      exp_w   = active && wr_valid && (!rd_ok || m_last_rd);
      exp_r   = active && rd_ok && !exp_w;
      exp_en  = (wq.size() != 0) ? !w_cmd_done : (rq.size() != 0);
      exp_wren = (wq.size() != 0) && !w_data_done;

      chk1("rnd_wr_ready", wr_ready, exp_w);
      chk1("rnd_rd_ready", rd_ready, exp_r);
      chk1("rnd_app_en", app_en, exp_en);
      chk1("rnd_wdf_wren", app_wdf_wren, exp_wren);
      chk1("rnd_wdf_end", app_wdf_end, exp_wren);
      chk1("rnd_frame_done", frame_done, exp_fd);
      chk1("rnd_rd_data_valid", rd_data_valid, app_rd_data_valid);
      chkw("rnd_rd_data", rd_data, app_rd_data);
      chkw("rnd_wdf_mask", 32'(app_wdf_mask), 32'd0);
      if (wq.size() != 0) begin
         if (!w_cmd_done) begin
            chkw("rnd_wr_addr", 32'(app_addr), 32'(wq[0].addr));
            chkw("rnd_wr_cmd", 32'(app_cmd), 32'd0);
         end
         if (!w_data_done) chkw("rnd_wr_data", app_wdf_data, wq[0].data);
      end else if (rq.size() != 0) begin
         chkw("rnd_rd_addr", 32'(app_addr), 32'(rq[0]));
         chkw("rnd_rd_cmd", 32'(app_cmd), 32'd1);
      end

      // Advance the model by what the coming edge will do.
      exp_fd = 1'b0;
      if (exp_en && app_rdy) begin
         if (wq.size() != 0) begin
            w_cmd_done = 1'b1;
         end else begin
            void'(rq.pop_front());
            m_out++;
         end
      end
      if (exp_wren && app_wdf_rdy) w_data_done = 1'b1;
      if (wq.size() != 0 && w_cmd_done && w_data_done) begin
         exp_fd = wq[0].fe;
         void'(wq.pop_front());
         w_cmd_done = 1'b0;
         w_data_done = 1'b0;
      end
      if (app_rd_data_valid) m_out--;
      wr_acc = exp_w;
      rd_acc = exp_r;
      if (exp_w) begin
         wq.push_back('{addr: m_waddr, data: wr_data, fe: wr_frame_end});
         m_waddr = wr_frame_end ? '0 : m_waddr + AW'(32);
         m_last_rd = 1'b0;
         grants++;
      end
      if (exp_r) begin
         rq.push_back(rd_addr);
         m_last_rd = 1'b1;
         grants++;
      end
      tick;
   endtask

   // ---------------- grant / passthrough vectors, each from fresh reset ----------------
   typedef struct {
      logic        calib, wv, rv, dv;
      logic [31:0] dd;
      logic        ewr, erd;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n, g, cnt;
      logic [AW-1:0] exp_a[4];

      tbl = '{
         '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0}
      };

      // Reset state, with requests pending while reset is held.
      do_reset;
      ui_clk_sync_rst = 1'b1;
      init_calib_complete = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
      #1;
      chk1("rst_wr_ready", wr_ready, 1'b0);
      chk1("rst_rd_ready", rd_ready, 1'b0);
      chk1("rst_app_en", app_en, 1'b0);
      chk1("rst_wdf_wren", app_wdf_wren, 1'b0);
      chk1("rst_wdf_end", app_wdf_end, 1'b0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chkw("rst_app_addr", 32'(app_addr), 32'd0);
      chkw("rst_app_cmd", 32'(app_cmd), 32'd0);
      chkw("rst_wdf_data", app_wdf_data, 32'd0);
      chkw("rst_wdf_mask", 32'(app_wdf_mask), 32'd0);

      for (int i = 0; i < 8; i++) begin
         do_reset;
         init_calib_complete = tbl[i].calib;
         wr_valid = tbl[i].wv;
         rd_valid = tbl[i].rv;
         app_rd_data_valid = tbl[i].dv;
         app_rd_data = tbl[i].dd;
         #1;
         chk1($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].ewr);
         chk1($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].erd);
         chk1($sformatf("tbl%0d_rd_data_valid", i), rd_data_valid, tbl[i].dv);
         chkw($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].dd);
         chk1($sformatf("tbl%0d_app_en", i), app_en, 1'b0);
      end

      // Calibration gate, then two consecutive writes.
      do_reset;
      wr_valid = 1'b1; wr_data = 32'hAABB_CCDD; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      repeat (3) begin
         #1;
         chk1("calib_lo_wr_ready", wr_ready, 1'b0);
         chk1("calib_lo_app_en", app_en, 1'b0);
         tick;
      end
      init_calib_complete = 1'b1;
      wait_ready(1'b0, "a_grant0");
      tick;
      wr_data = 32'h1122_3344;
      chkw("a_addr0", 32'(app_addr), 32'd0);
      chkw("a_data0", app_wdf_data, 32'hAABB_CCDD);
      chkw("a_cmd0", 32'(app_cmd), 32'd0);
      chk1("a_en0", app_en, 1'b1);
      chk1("a_wren0", app_wdf_wren, 1'b1);
      chk1("a_end0", app_wdf_end, 1'b1);
      wait_ready(1'b0, "a_grant1");
      tick;
      wr_valid = 1'b0;
      chkw("a_addr1", 32'(app_addr), 32'd32);
      chkw("a_data1", app_wdf_data, 32'h1122_3344);
      tick;

      // Command accepted three cycles before the data.
      do_reset;
      init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b0;
      wr_valid = 1'b1; wr_data = 32'h5555_AAAA;
      wait_ready(1'b0, "b_grant");
      tick;
      wr_data = 32'h0BAD_F00D;
      cnt = (app_en && app_rdy) ? 1 : 0;
      chk1("b_en_first", app_en, 1'b1);
      repeat (3) begin
         tick;
         if (app_en && app_rdy) cnt++;
         chk1("b_en_dropped", app_en, 1'b0);
         chk1("b_wren_held", app_wdf_wren, 1'b1);
         chk1("b_end_held", app_wdf_end, 1'b1);
         chk1("b_no_grant", wr_ready, 1'b0);
         chkw("b_data_held", app_wdf_data, 32'h5555_AAAA);
      end
      app_wdf_rdy = 1'b1;
      tick;
      chk1("b_wren_done", app_wdf_wren, 1'b0);
      chk1("b_end_done", app_wdf_end, 1'b0);
      chk1("b_en_done", app_en, 1'b0);
      chk1("b_regrant", wr_ready, 1'b1);
      chkw("b_cmd_count", 32'(cnt), 32'd1);
      wr_valid = 1'b0;
      tick;

      // Both requesters held high: grants alternate W, R, W, R.
      do_reset;
      init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = AW'(32'h100);
      g = 0;
      for (int c = 0; c < 30 && g < 4; c++) begin
         #1;
         if (wr_ready || rd_ready) begin
            chk1($sformatf("alt_grant%0d_is_rd", g), rd_ready, g[0]);
            g++;
         end
         tick;
      end
      chkw("alt_grant_count", 32'(g), 32'd4);
      wr_valid = 1'b0; rd_valid = 1'b0;
      tick;

      // Frame of three words, then the next frame restarts at address 0.
      do_reset;
      init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      exp_a = '{AW'(0), AW'(32), AW'(64), AW'(0)};
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_frame_end = (i == 2); wr_data = 32'(i);
         wait_ready(1'b0, $sformatf("d_grant%0d", i));
         tick;
         wr_valid = 1'b0; wr_frame_end = 1'b0;
         chkw($sformatf("d_addr%0d", i), 32'(app_addr), 32'(exp_a[i]));
         chk1($sformatf("d_fd_busy%0d", i), frame_done, 1'b0);
         tick;
         chk1($sformatf("d_fd_after%0d", i), frame_done, i == 2);
      end
      tick;
      chk1("d_fd_final", frame_done, 1'b0);

      // Outstanding-read limit.
      do_reset;
      init_calib_complete = 1'b1;
      count_reads(20, n);
      chkw("e_reads_limited", 32'(n), 32'd4);
      app_rd_data_valid = 1'b1;
      #1;
      chk1("e_rd_ready_blocked", rd_ready, 1'b0);
      chk1("e_return_pass", rd_data_valid, 1'b1);
      tick;
      app_rd_data_valid = 1'b0;
      count_reads(10, n);
      chkw("e_fifth_read", 32'(n), 32'd1);
      rd_valid = 1'b0;
      tick;

      // Reset while a write waits on app_rdy.
      do_reset;
      init_calib_complete = 1'b1; app_wdf_rdy = 1'b1;
      count_reads(4, n);
      rd_valid = 1'b0;
      chkw("f_pre_reads", 32'(n), 32'd2);
      wr_valid = 1'b1;
      wait_ready(1'b0, "f_grant0");
      tick;
      wr_valid = 1'b0;
      tick;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; wr_valid = 1'b1;
      wait_ready(1'b0, "f_grant1");
      tick;
      wr_valid = 1'b0;
      chk1("f_en_pending", app_en, 1'b1);
      chkw("f_addr_pending", 32'(app_addr), 32'd32);
      ui_clk_sync_rst = 1'b1;
      tick;
      ui_clk_sync_rst = 1'b0;
      chk1("f_en_cleared", app_en, 1'b0);
      chk1("f_wren_cleared", app_wdf_wren, 1'b0);
      chkw("f_addr_cleared", 32'(app_addr), 32'd0);
      tick;
      chk1("f_en_stays_low", app_en, 1'b0);
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_valid = 1'b1;
      wait_ready(1'b0, "f_grant2");
      tick;
      wr_valid = 1'b0;
      chkw("f_addr_restart", 32'(app_addr), 32'd0);
      tick;
      count_reads(20, n);
      rd_valid = 1'b0;
      chkw("f_outstanding_cleared", 32'(n), 32'd4);

      // Random traffic.
      do_reset;
      model_reset;
      for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
      n = 0;
      while ((wq.size() != 0 || rq.size() != 0) && n < 50) begin
         rand_cycle(1'b1);
         n++;
      end
      chk1("rnd_drained", (wq.size() == 0) && (rq.size() == 0), 1'b1);
      chk1("rnd_enough_grants", grants > 200, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mig_arbiter.md
MIG_ARBITER -- requirements
Module: mig_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 28, MIG app_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, app data width (4 preprocessed 8-bit points).
REQ-003 SHALL have parameter START_ADDRESS, 0, first write address of every frame.
REQ-004 SHALL have parameter ADDR_STEP, 32, write-address increment per accepted word.
REQ-005 SHALL have parameter MAX_RD_OUTSTANDING, 4, read commands in flight limit (power of two, >=2).
REQ-006 SHALL have a single clock and reset: ui_clk and ui_clk_sync_rst; reset is synchronous and active-high.
REQ-007 SHALL have ports (name dir width meaning):
- ui_clk in 1 MIG user clock, all logic on rising edge
- ui_clk_sync_rst in 1 synchronous active-high reset
- init_calib_complete in 1 MIG calibration done; no grants while low
- wr_valid in 1 / wr_ready out 1 / wr_data in DATA_WIDTH / wr_frame_end in 1 write requester; frame_end marks last word of frame
- rd_valid in 1 / rd_ready out 1 / rd_addr in ADDR_WIDTH read requester
- rd_data out DATA_WIDTH / rd_data_valid out 1 read return
- frame_done out 1 one-cycle pulse after last word of a frame is committed
- app_addr out ADDR_WIDTH, app_cmd out 3, app_en out 1, app_rdy in 1
- app_wdf_data out DATA_WIDTH, app_wdf_mask out DATA_WIDTH/8, app_wdf_wren out 1, app_wdf_end out 1, app_wdf_rdy in 1
- app_rd_data in DATA_WIDTH, app_rd_data_valid in 1

Function
REQ-008 SHALL implement FSM states IDLE, WR_ISSUE, RD_ISSUE.
REQ-009 In IDLE with init_calib_complete=1 SHALL grant one requester per cycle: single valid requester wins; both valid -> round-robin, opposite of last grant; last grant after reset = read (write wins first tie).
REQ-010 wr_ready/rd_ready SHALL be combinational, high only in IDLE, calib done, and granted; rd_ready additionally requires outstanding count < MAX_RD_OUTSTANDING (if blocked, write takes grant).
REQ-011 Write accept (wr_valid&wr_ready, cycle N) SHALL register data, frame_end, and enter WR_ISSUE; app_en, app_wdf_wren, app_wdf_end high from N+1, app_cmd=3'b000, app_addr=current write address, app_wdf_mask=0.
REQ-012 In WR_ISSUE app_en SHALL drop the cycle after app_rdy is sampled high; app_wdf_wren/app_wdf_end SHALL drop the cycle after app_wdf_rdy is sampled high; each independent, either order or same cycle.
REQ-013 When both command and data accepted, SHALL return to IDLE next cycle and add ADDR_STEP to write address (modulo 2^ADDR_WIDTH wrap).
REQ-014 If registered frame_end=1, write address SHALL instead load START_ADDRESS and frame_done SHALL pulse for exactly one cycle, same cycle as the IDLE return.
REQ-015 Read accept SHALL enter RD_ISSUE, app_cmd=3'b001, app_addr=rd_addr, app_en high from next cycle until the cycle after app_rdy sampled high, then IDLE; app_wdf_wren stays 0.
REQ-016 Outstanding counter SHALL increment on read command accept (app_en&app_rdy in RD_ISSUE), decrement on app_rd_data_valid, unchanged if both same cycle; never exceed MAX_RD_OUTSTANDING.
REQ-017 rd_data/rd_data_valid SHALL be app_rd_data/app_rd_data_valid passed through combinationally.
REQ-018 app_addr, app_cmd, app_wdf_data SHALL hold stable while the corresponding enable is high.
REQ-019 init_calib_complete falling mid-transaction SHALL NOT abort it; only new grants blocked.

Reset
REQ-020 On ui_clk_sync_rst=1 SHALL go IDLE; app_en, app_wdf_wren, app_wdf_end, wr_ready, rd_ready, frame_done = 0; app_addr, app_cmd, app_wdf_data, app_wdf_mask = 0; write address = START_ADDRESS; outstanding = 0; last grant = read.
REQ-021 Reset mid-transaction SHALL drop the pending command with no further app_en/app_wdf_wren assertion; rd_data_valid still passes through.

Verification
REQ-022 Calib low, wr_valid=1 -> wr_ready=0, app_en=0 until calib rises; then word 0xAABBCCDD written at address 0, next at 32.
REQ-023 app_rdy high 3 cycles before app_wdf_rdy -> app_en drops first, wr_wren held until app_wdf_rdy; single write recorded; no new grant before both done.
REQ-024 wr_valid and rd_valid held high together -> grants alternate W,R,W,R; first grant write.
REQ-025 3 words, third with wr_frame_end=1 -> addresses 0,32,64; frame_done one pulse; fourth word at address 0.
REQ-026 5 reads, no app_rd_data_valid -> 4 commands issued, rd_ready=0; one valid return -> fifth issued.
REQ-027 Reset asserted while app_en=1 waiting on app_rdy -> next cycle app_en=0, write address 0, outstanding 0.
